// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational one-bit full adder cell
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - ripple-carry adder with registered sum, carry-out and valid
module adder_pipe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder_cell u_fa (
            .a   (A[i]),
            .b   (B[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Sum/Cout only load on accepted inputs so idle cycles never toggle them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            Sum       <= s;
            Cout      <= c[WIDTH];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe at WIDTH=1 and WIDTH=8
module tb_adder_pipe;

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic       sum;
        logic       cout;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec8_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid1, in_valid8;
    logic [0:0] a1, b1;
    logic       cin1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       out_valid1, out_valid8;
    logic [0:0] sum1;
    logic       cout1;
    logic [7:0] sum8;
    logic       cout8;

    int total = 0;
    int bad   = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [1:0] held1;
    logic [8:0] held8;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid1),
        .A        (a1),
        .B        (b1),
        .Cin      (cin1),
        .out_valid(out_valid1),
        .Sum      (sum1),
        .Cout     (cout1)
    );

    adder_pipe #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid8),
        .A        (a8),
        .B        (b8),
        .Cin      (cin8),
        .out_valid(out_valid8),
        .Sum      (sum8),
        .Cout     (cout8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        q8.push_back(t);
    endtask

    task automatic push1(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = {1'b0, a} + {1'b0, b} + {1'b0, c};
        q1.push_back(t);
    endtask

    // Drive one cycle on both instances, then check one edge later against the scoreboard.
    task automatic step(input logic r,
                        input logic v1, input logic ai1, input logic bi1, input logic ci1,
                        input logic v8, input logic [7:0] ai8, input logic [7:0] bi8,
                        input logic ci8);
        rst_n = r;
        in_valid1 = v1; a1 = ai1; b1 = bi1; cin1 = ci1;
        in_valid8 = v8; a8 = ai8; b8 = bi8; cin8 = ci8;
        @(posedge clk);
        #1;
        if (!r) begin
            held1 = '0;
            held8 = '0;
        end else begin
            if (v1) begin
                if (q1.size() == 0) chk("q1_underflow", 1, 0);
                else held1 = q1.pop_front();
            end
            if (v8) begin
                if (q8.size() == 0) chk("q8_underflow", 1, 0);
                else held8 = q8.pop_front();
            end
        end
        chk("w1_out_valid", out_valid1, r & v1);
        chk("w1_sum",       sum1,       held1[0]);
        chk("w1_cout",      cout1,      held1[1]);
        chk("w8_out_valid", out_valid8, r & v8);
        chk("w8_sum",       sum8,       held8[7:0]);
        chk("w8_cout",      cout8,      held8[8]);
    endtask

    initial begin
        vec1_t t1[5];
        vec8_t t8[3];
        logic [7:0] ra, rb;
        logic       rc;

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        t1[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        t1[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        t8[1] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
        t8[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        held1 = '0;
        held8 = '0;

        // Reset held with valid inputs present
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0);

        for (int i = 0; i < 5; i++) begin
            q1.push_back({t1[i].cout, t1[i].sum});
            step(1'b1, 1'b1, t1[i].a, t1[i].b, t1[i].cin, 1'b0, 8'h00, 8'h00, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            q8.push_back({t8[i].cout, t8[i].sum});
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t8[i].a, t8[i].b, t8[i].cin);
        end

        // Hold: one valid result, then idle cycles with changing or unknown operands
        q8.push_back({1'b0, 8'h30});
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b0);

        // Streaming: four back-to-back pairs on both widths
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            push8(ra, rb, rc);
            push1(ra[0], rb[0], rc);
            step(1'b1, 1'b1, ra[0], rb[0], rc, 1'b1, ra, rb, rc);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Mid-stream reset discards the in-flight input on that edge
        push8(8'hA5, 8'h5A, 1'b1);
        push1(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99, 8'h11, 1'b0);
        push8(8'h80, 8'h80, 1'b0);
        push1(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        chk("q1_drained", 64'(q1.size()), 0);
        chk("q8_drained", 64'(q8.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
